// File: rtl/manchester_rx_axis_packer.sv
// Packs decoded Manchester bytes into AXI4-Stream packets: a staging register holds the newest
// byte until its tlast is known (next byte, idle gap or length limit), then a FWFT FIFO buffers it.
module manchester_rx_axis_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 32,
  parameter int MAX_LEN    = 256
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int GW   = $clog2(GAP_CYCLES);
  localparam int LENW = $clog2(MAX_LEN + 1);
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [LENW-1:0] LEN_LAST = LENW'(MAX_LEN - 1);
  localparam logic [LW-1:0]   FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {ST_EMPTY, ST_HELD} stage_t;

  stage_t          state, state_nxt;
  logic [7:0]      stage_data;
  logic [GW-1:0]   gap_cnt;
  logic [LENW-1:0] len_cnt;
  logic            gap_done;
  logic            push, push_last;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            pop, accept, full;
  logic [8:0]      head;

  assign gap_done = (gap_cnt == GAP_LAST);

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // in_valid always wins over gap expiry
  always_comb begin
    state_nxt = state;
    if (in_valid)                          state_nxt = ST_HELD;
    else if (state == ST_HELD && gap_done) state_nxt = ST_EMPTY;
  end

  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (state == ST_HELD) begin
      if (in_valid) begin
        push      = 1'b1;
        push_last = (len_cnt == LEN_LAST);
      end else if (gap_done) begin
        push      = 1'b1;
        push_last = 1'b1;
      end
    end
  end

  // len_cnt advances on every push, dropped or not, so framing stays aligned
  always_ff @(posedge aclk) begin
    if (areset) begin
      stage_data <= '0;
      gap_cnt    <= '0;
      len_cnt    <= '0;
    end else begin
      if (in_valid) begin
        stage_data <= in_data;
        gap_cnt    <= '0;
      end else if (state == ST_HELD) begin
        gap_cnt    <= gap_cnt + 1'b1;
      end
      if (push) len_cnt <= push_last ? '0 : len_cnt + 1'b1;
    end
  end

  assign full   = (level == FULL_LVL);
  assign pop    = m_axis_tvalid & m_axis_tready;
  assign accept = push & (~full | pop);

  always_ff @(posedge aclk) begin
    if (accept) mem[wr_ptr] <= {push_last, stage_data};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && !accept) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

  // head is gated so stale/unwritten memory never shows on the bus
  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (level != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[7:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid ? head[8]   : 1'b0;
  assign fifo_level    = level;

endmodule

// File: tb/tb_manchester_rx_axis_packer.sv
// Scoreboard bench: a packet-level model queues expected {tlast,data}; a negedge monitor pops on handshakes.
module tb_manchester_rx_axis_packer;

  localparam int DEPTH = 16;
  localparam int GAP   = 32;
  localparam int MAXL  = 4;

  logic        aclk = 1'b0;
  logic        areset, in_valid, tready;
  logic [7:0]  in_data;
  logic [7:0]  tdata;
  logic        tvalid, tlast, overflow;
  logic [15:0] drop_count;
  logic [4:0]  fifo_level;

  manchester_rx_axis_packer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .MAX_LEN(MAXL)) dut (
    .aclk(aclk), .areset(areset), .in_data(in_data), .in_valid(in_valid),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .overflow(overflow), .drop_count(drop_count),
    .fifo_level(fifo_level));

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet framing from byte positions and idle gaps
  logic [8:0] expq[$];
  logic [7:0] pend_data;
  bit         pend, blocked;
  int         cnt, idle, held, exp_drops;

  task automatic model_push(input bit last);
    if (blocked && held >= DEPTH) exp_drops++;
    else begin
      expq.push_back({last, pend_data});
      held++;
    end
    cnt = last ? 0 : cnt + 1;
  endtask

  task automatic tick(input bit iv, input logic [7:0] d, input bit rdy);
    in_valid = iv;
    in_data  = d;
    tready   = rdy;
    if (iv) begin
      if (pend) model_push(cnt + 1 == MAXL);
      pend = 1;
      pend_data = d;
      idle = 0;
    end else if (pend) begin
      idle++;
      if (idle == GAP) begin
        model_push(1'b1);
        pend = 0;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((expq.size() != 0 || pend) && budget < 2000) begin
      tick(1'b0, 8'h00, 1'b1);
      budget++;
    end
    repeat (3) tick(1'b0, 8'h00, 1'b1);
    chk("drain_empty", expq.size(), 0);
  endtask

  always @(negedge aclk) begin
    if (!areset && tvalid && tready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h with tlast=%0b, expected nothing", tdata, tlast);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        chk("beat", {23'd0, tlast, tdata}, {23'd0, e});
      end
    end
  end

  initial begin
    areset = 1'b1; in_valid = 1'b0; in_data = '0; tready = 1'b0;
    pend = 0; blocked = 0; cnt = 0; idle = 0; held = 0; exp_drops = 0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_level", fifo_level, 0);
    areset = 1'b0;

    // 1: three bytes, 9-cycle spacing, packet closed by idle gap
    tick(1'b1, 8'hF0, 1'b1); repeat (8) tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h0F, 1'b1); repeat (8) tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'hAA, 1'b1);
    repeat (GAP - 1) tick(1'b0, 8'h00, 1'b1);
    chk("gap_early_tvalid", tvalid, 0);
    tick(1'b0, 8'h00, 1'b1);
    chk("gap_tvalid", tvalid, 1);
    chk("gap_head", {tlast, tdata}, 9'h1AA);
    drain();

    // 2: two bursts separated by a long gap
    tick(1'b1, 8'h11, 1'b1); tick(1'b1, 8'h22, 1'b1);
    repeat (GAP + 5) tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h33, 1'b1); tick(1'b1, 8'h44, 1'b1);
    drain();

    // 3: max length split
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 8'(i), 1'b1);
      tick(1'b0, 8'h00, 1'b1);
    end
    drain();

    // random traffic with random backpressure
    for (int n = 0; n < 60; n++) begin
      int sp;
      tick(1'b1, 8'($urandom), $urandom_range(0, 3) != 0);
      sp = ($urandom_range(0, 9) == 0) ? GAP + $urandom_range(0, 4) : $urandom_range(1, 6);
      repeat (sp) tick(1'b0, 8'h00, $urandom_range(0, 3) != 0);
    end
    drain();
    chk("rand_overflow", overflow, 0);
    chk("rand_drops", drop_count, 0);

    // 4: overflow with tready held low
    blocked = 1; held = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 8'(8'h80 + i), 1'b0);
      if (i != 20) tick(1'b0, 8'h00, 1'b0);
    end
    chk("ovf_level", fifo_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_count, 3);
    chk("ovf_model_drops", drop_count, exp_drops);

    // 5: full FIFO, push and pop in the same cycle
    blocked = 0;
    tick(1'b1, 8'hC5, 1'b1);
    chk("full_pushpop_level", fifo_level, 16);
    chk("full_pushpop_drops", drop_count, 3);
    drain();
    chk("sticky_overflow", overflow, 1);

    // 6: reset mid-packet
    tick(1'b1, 8'hB1, 1'b0); tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hB2, 1'b0); tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hB3, 1'b0); tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hB4, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_level", fifo_level, 3);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_drops", drop_count, 0);
    areset = 1'b0;
    expq.delete();
    pend = 0; cnt = 0; idle = 0; exp_drops = 0;
    tick(1'b1, 8'h5A, 1'b1);
    repeat (GAP + 5) tick(1'b0, 8'h00, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
